// File: rtl/mul_arbiter_if.sv
// Purpose : handshake bundle between two requesters, one shared multiplier and two result ports.
// Latency : none; wires only.
// Backpr. : every channel is valid/ready; slave = arbiter side, master = requester/multiplier side.
// Ports   : in0_*/in1_* operand requests, mul_* multiplier issue/result, out*_* results, err_timeout.
interface mul_arbiter_if #(
    parameter int DATA_SIZE = 8
);
    logic                   in0_valid;
    logic [DATA_SIZE-1:0]   in0_a;
    logic [DATA_SIZE-1:0]   in0_b;
    logic                   in0_ready;
    logic                   in1_valid;
    logic [DATA_SIZE-1:0]   in1_a;
    logic [DATA_SIZE-1:0]   in1_b;
    logic                   in1_ready;

    logic                   mul_valid;
    logic [DATA_SIZE-1:0]   mul_a;
    logic [DATA_SIZE-1:0]   mul_b;
    logic                   mul_ready;
    logic                   mul_res_valid;
    logic [2*DATA_SIZE-1:0] mul_res;
    logic                   mul_res_ready;

    logic                   out0_valid;
    logic                   out1_valid;
    logic [2*DATA_SIZE-1:0] out_data;
    logic                   out0_ready;
    logic                   out1_ready;

    logic                   err_timeout;

    modport slave (
        input  in0_valid, in0_a, in0_b, in1_valid, in1_a, in1_b,
        output in0_ready, in1_ready,
        output mul_valid, mul_a, mul_b,
        input  mul_ready, mul_res_valid, mul_res,
        output mul_res_ready,
        output out0_valid, out1_valid, out_data,
        input  out0_ready, out1_ready,
        output err_timeout
    );

    modport master (
        output in0_valid, in0_a, in0_b, in1_valid, in1_a, in1_b,
        input  in0_ready, in1_ready,
        input  mul_valid, mul_a, mul_b,
        output mul_ready, mul_res_valid, mul_res,
        input  mul_res_ready,
        input  out0_valid, out1_valid, out_data,
        output out0_ready, out1_ready,
        input  err_timeout
    );
endinterface

// File: rtl/mul_arbiter.sv
// Purpose : round-robin arbiter sharing one multiplier between two requesters, one op in flight.
// Latency : accept -> issue -> capture -> out*_valid in the 4th cycle at best; WAIT aborts after TIMEOUT cycles.
// Backpr. : ready only in IDLE; mul_valid and out*_valid hold until accepted; err_timeout is a 1-cycle pulse.
// Ports   : clk, rst (sync, active-high), bus (mul_arbiter_if.slave).
module mul_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         rst,
    mul_arbiter_if.slave bus
);
    // Counter value seen in the last WAIT cycle before an abort.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t                 state_q,      state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   owner_q,      owner_d;
    logic [DATA_SIZE-1:0]   op_a_q,       op_a_d;
    logic [DATA_SIZE-1:0]   op_b_q,       op_b_d;
    logic [2*DATA_SIZE-1:0] out_data_q,   out_data_d;
    logic [7:0]             cnt_q,        cnt_d;
    logic                   err_q,        err_d;

    logic grant;
    logic any_req;

    // On a tie the requester that did not complete last wins; otherwise
    // whichever is valid. With no request the value is irrelevant.
    always_comb begin
        any_req = bus.in0_valid | bus.in1_valid;
        if (bus.in0_valid && bus.in1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = ~bus.in0_valid;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        out_data_d   = out_data_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = grant;
                    op_a_d  = grant ? bus.in1_a : bus.in0_a;
                    op_b_d  = grant ? bus.in1_b : bus.in0_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mul_ready) begin
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A result on the final allowed cycle still wins over the abort.
                if (bus.mul_res_valid) begin
                    out_data_d = bus.mul_res;
                    state_d    = DELIVER;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d        = 1'b1;
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            DELIVER: begin
                if (owner_q ? bus.out1_ready : bus.out0_ready) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            out_data_q   <= '0;
            cnt_q        <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            out_data_q   <= out_data_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign bus.in0_ready     = (state_q == IDLE) && bus.in0_valid && !grant;
    assign bus.in1_ready     = (state_q == IDLE) && bus.in1_valid &&  grant;
    assign bus.mul_valid     = (state_q == ISSUE);
    assign bus.mul_a         = op_a_q;
    assign bus.mul_b         = op_b_q;
    assign bus.mul_res_ready = (state_q == WAIT);
    assign bus.out0_valid    = (state_q == DELIVER) && !owner_q;
    assign bus.out1_valid    = (state_q == DELIVER) &&  owner_q;
    assign bus.out_data      = out_data_q;
    assign bus.err_timeout   = err_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// Purpose : self-checking bench for mul_arbiter: tables, directed corner sequences, random vs. model.
// Latency : n/a.
// Backpr. : bench plays both requesters, the multiplier and both result consumers.
module tb_mul_arbiter;
    localparam int DW   = 8;
    localparam int TO_D = 64;
    localparam int TO_T = 8;

    // Flag order: {in0_ready, in1_ready, mul_valid, mul_res_ready, out0_valid, out1_valid, err_timeout}
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_IN0  = 7'b1000000;
    localparam logic [6:0] F_IN1  = 7'b0100000;
    localparam logic [6:0] F_MULV = 7'b0010000;
    localparam logic [6:0] F_RESR = 7'b0001000;
    localparam logic [6:0] F_OUT0 = 7'b0000100;
    localparam logic [6:0] F_OUT1 = 7'b0000010;
    localparam logic [6:0] F_ERR  = 7'b0000001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_arbiter_if #(.DATA_SIZE(DW)) if_d ();
    mul_arbiter_if #(.DATA_SIZE(DW)) if_t ();

    mul_arbiter #(.DATA_SIZE(DW), .TIMEOUT(TO_D)) u_dut    (.clk(clk), .rst(rst), .bus(if_d.slave));
    mul_arbiter #(.DATA_SIZE(DW), .TIMEOUT(TO_T)) u_dut_to (.clk(clk), .rst(rst), .bus(if_t.slave));

    // The short-timeout instance sees exactly the same stimulus.
    assign if_t.in0_valid     = if_d.in0_valid;
    assign if_t.in0_a         = if_d.in0_a;
    assign if_t.in0_b         = if_d.in0_b;
    assign if_t.in1_valid     = if_d.in1_valid;
    assign if_t.in1_a         = if_d.in1_a;
    assign if_t.in1_b         = if_d.in1_b;
    assign if_t.mul_ready     = if_d.mul_ready;
    assign if_t.mul_res_valid = if_d.mul_res_valid;
    assign if_t.mul_res       = if_d.mul_res;
    assign if_t.out0_ready    = if_d.out0_ready;
    assign if_t.out1_ready    = if_d.out1_ready;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic v0;
        logic v1;
        logic r0;
        logic r1;
    } arb_vec_t;

    typedef struct {
        int grant;
        int res;
    } cont_vec_t;

    arb_vec_t  arb_tbl[4];
    cont_vec_t cont_tbl[4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] flags_d();
        return {if_d.in0_ready, if_d.in1_ready, if_d.mul_valid, if_d.mul_res_ready,
                if_d.out0_valid, if_d.out1_valid, if_d.err_timeout};
    endfunction

    function automatic logic [6:0] flags_t();
        return {if_t.in0_ready, if_t.in1_ready, if_t.mul_valid, if_t.mul_res_ready,
                if_t.out0_valid, if_t.out1_valid, if_t.err_timeout};
    endfunction

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return if_d.in0_ready | if_d.in1_ready;
            1:       return if_d.mul_valid;
            2:       return if_d.mul_res_ready;
            default: return if_d.out0_valid | if_d.out1_valid;
        endcase
    endfunction

    // Returns at the negedge where the selected signal is high (or after the budget).
    task automatic wait_sig(input int sel, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!get_sig(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!get_sig(sel)) begin
            n_err++;
            $display("FAIL %s: event not seen within 200 cycles", name);
        end
    endtask

    task automatic clear_inputs();
        if_d.in0_valid = 1'b0; if_d.in0_a = '0; if_d.in0_b = '0;
        if_d.in1_valid = 1'b0; if_d.in1_a = '0; if_d.in1_b = '0;
        if_d.mul_ready = 1'b0; if_d.mul_res_valid = 1'b0; if_d.mul_res = '0;
        if_d.out0_ready = 1'b0; if_d.out1_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation on the default instance with mul_ready and out ready held high.
    task automatic run_op(input int req, input logic [7:0] a, input logic [7:0] b, input int lat);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        if_d.mul_ready = 1'b1; if_d.out0_ready = 1'b1; if_d.out1_ready = 1'b1;
        if_d.mul_res_valid = 1'b0;
        if (req == 0) begin if_d.in0_valid = 1'b1; if_d.in0_a = a; if_d.in0_b = b; end
        else          begin if_d.in1_valid = 1'b1; if_d.in1_a = a; if_d.in1_b = b; end
        wait_sig(0, "op_ready");
        chk("op_grant", {if_d.in0_ready, if_d.in1_ready}, (req == 0) ? 2'b10 : 2'b01);
        step();
        if_d.in0_valid = 1'b0; if_d.in1_valid = 1'b0;
        wait_sig(1, "op_mulv");
        chk("op_mul_a", if_d.mul_a, a);
        chk("op_mul_b", if_d.mul_b, b);
        step();
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("op_wait", flags_d(), F_RESR);
            step();
        end
        if_d.mul_res_valid = 1'b1; if_d.mul_res = p;
        @(negedge clk);
        chk("op_capture", flags_d(), F_RESR);
        step();
        if_d.mul_res_valid = 1'b0;
        @(negedge clk);
        chk("op_deliver", flags_d(), (req == 0) ? F_OUT0 : F_OUT1);
        chk("op_data", if_d.out_data, p);
        step();
        @(negedge clk);
        chk("op_done", flags_d(), F_NONE);
    endtask

    // Random traffic against a transaction-level model of the spec rules.
    task automatic random_test(input int cycles);
        bit         v[2];
        logic [7:0] ra[2];
        logic [7:0] rb[2];
        int ph, owner, last, k, lat, g, opa, opb;
        bit err_exp, err_nxt;
        logic [6:0] exp_flags;
        v[0] = 1'b0; v[1] = 1'b0;
        ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
        ph = 0; owner = 0; last = 1; k = 0; lat = 0; opa = 0; opb = 0; err_exp = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i]  = 1'b1;
                    ra[i] = 8'($urandom);
                    rb[i] = 8'($urandom);
                end
            end
            if_d.in0_valid = v[0]; if_d.in0_a = ra[0]; if_d.in0_b = rb[0];
            if_d.in1_valid = v[1]; if_d.in1_a = ra[1]; if_d.in1_b = rb[1];
            if_d.mul_ready = 1'($urandom);
            if (ph == 2) begin
                if_d.mul_res_valid = (k == lat);
                if_d.mul_res       = 16'(opa * opb);
            end else begin
                if_d.mul_res_valid = 1'($urandom);
                if_d.mul_res       = 16'($urandom);
            end
            if_d.out0_ready = 1'($urandom);
            if_d.out1_ready = 1'($urandom);

            @(negedge clk);
            g = (v[0] && v[1]) ? (1 - last) : (v[0] ? 0 : 1);
            exp_flags = {ph == 0 && v[0] && g == 0, ph == 0 && v[1] && g == 1,
                         ph == 1, ph == 2, ph == 3 && owner == 0, ph == 3 && owner == 1, err_exp};
            chk("rnd_flags", flags_d(), exp_flags);
            if (ph == 1) begin
                chk("rnd_mul_a", if_d.mul_a, opa);
                chk("rnd_mul_b", if_d.mul_b, opb);
            end
            if (ph == 3) chk("rnd_out_data", if_d.out_data, opa * opb);

            err_nxt = 1'b0;
            case (ph)
                0: if (v[0] || v[1]) begin
                       owner = g;
                       opa   = int'(ra[g]);
                       opb   = int'(rb[g]);
                       v[g]  = 1'b0;
                       ph    = 1;
                   end
                1: if (if_d.mul_ready) begin
                       ph  = 2;
                       k   = 0;
                       lat = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 10))
                                                         : int'($urandom_range(TO_D - 4, TO_D + 4));
                   end
                2: if (k == lat) ph = 3;
                   else if (k == TO_D - 1) begin
                       ph      = 0;
                       last    = owner;
                       err_nxt = 1'b1;
                   end else k++;
                default: if ((owner == 0 && if_d.out0_ready) || (owner == 1 && if_d.out1_ready)) begin
                       ph   = 0;
                       last = owner;
                   end
            endcase
            err_exp = err_nxt;
        end
    endtask

    initial begin
        logic [15:0] prod;
        arb_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        arb_tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        arb_tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        arb_tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        cont_tbl[0] = '{0, 4};
        cont_tbl[1] = '{1, 49};
        cont_tbl[2] = '{0, 4};
        cont_tbl[3] = '{1, 49};

        // Reset values and IDLE arbitration, with rst held so nothing is accepted.
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", flags_d(), F_NONE);
        chk("rst_out_data", if_d.out_data, 0);
        chk("rst_mul_ops", {if_d.mul_a, if_d.mul_b}, 0);
        for (int i = 0; i < 4; i++) begin
            if_d.in0_valid = arb_tbl[i].v0;
            if_d.in1_valid = arb_tbl[i].v1;
            #1;
            chk($sformatf("arb_row%0d", i), {if_d.in0_ready, if_d.in1_ready},
                {arb_tbl[i].r0, arb_tbl[i].r1});
        end
        do_reset();

        // Minimum latency, requester 1.
        if_d.mul_ready = 1'b1; if_d.mul_res_valid = 1'b1; if_d.mul_res = 16'd99;
        if_d.in1_valid = 1'b1; if_d.in1_a = 8'd9; if_d.in1_b = 8'd11;
        @(negedge clk); chk("lat_c0", flags_d(), F_IN1);
        step(); if_d.in1_valid = 1'b0;
        @(negedge clk); chk("lat_c1", flags_d(), F_MULV);
        chk("lat_mul_ops", {if_d.mul_a, if_d.mul_b}, {8'd9, 8'd11});
        @(negedge clk); chk("lat_c2", flags_d(), F_RESR);
        @(negedge clk); chk("lat_c3", flags_d(), F_OUT1);
        chk("lat_data", if_d.out_data, 99);
        step(); if_d.out1_ready = 1'b1;
        step(); if_d.out1_ready = 1'b0;
        @(negedge clk); chk("lat_idle_ignores_res", flags_d(), F_NONE);

        // Contention: both requesters held valid.
        do_reset();
        if_d.mul_ready = 1'b1; if_d.out0_ready = 1'b1; if_d.out1_ready = 1'b1;
        if_d.in0_valid = 1'b1; if_d.in0_a = 8'd2; if_d.in0_b = 8'd2;
        if_d.in1_valid = 1'b1; if_d.in1_a = 8'd7; if_d.in1_b = 8'd7;
        for (int op = 0; op < 4; op++) begin
            wait_sig(0, "cont_ready");
            chk("cont_grant", {if_d.in0_ready, if_d.in1_ready},
                (cont_tbl[op].grant == 0) ? 2'b10 : 2'b01);
            step();
            wait_sig(1, "cont_mulv");
            prod = 16'(if_d.mul_a) * 16'(if_d.mul_b);
            step();
            if_d.mul_res_valid = 1'b1; if_d.mul_res = prod;
            wait_sig(2, "cont_resrdy");
            step();
            if_d.mul_res_valid = 1'b0;
            wait_sig(3, "cont_outv");
            chk("cont_port", {if_d.out0_valid, if_d.out1_valid},
                (cont_tbl[op].grant == 0) ? 2'b10 : 2'b01);
            chk("cont_data", if_d.out_data, cont_tbl[op].res);
            step();
        end

        // Backpressure on the multiplier and on the owning output.
        do_reset();
        if_d.in0_valid = 1'b1; if_d.in0_a = 8'd6; if_d.in0_b = 8'd9; if_d.out1_ready = 1'b1;
        wait_sig(0, "bp_ready");
        step(); if_d.in0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_issue_hold", flags_d(), F_MULV);
            chk("bp_issue_ops", {if_d.mul_a, if_d.mul_b}, {8'd6, 8'd9});
            step();
        end
        if_d.mul_ready = 1'b1;
        @(negedge clk); chk("bp_issue_last", flags_d(), F_MULV);
        step();
        if_d.mul_ready = 1'b0; if_d.mul_res_valid = 1'b1; if_d.mul_res = 16'd54;
        @(negedge clk); chk("bp_one_issue", flags_d(), F_RESR);
        step(); if_d.mul_res_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_hold", flags_d(), F_OUT0);
            chk("bp_out_data", if_d.out_data, 54);
            step();
        end
        if_d.out0_ready = 1'b1;
        @(negedge clk); chk("bp_out_last", flags_d(), F_OUT0);
        step(); if_d.out0_ready = 1'b0;
        @(negedge clk); chk("bp_one_delivery", flags_d(), F_NONE);

        // Single request with a 9-cycle multiplier, then reset during WAIT.
        do_reset();
        run_op(0, 8'd3, 8'd5, 9);
        step();
        if_d.in0_valid = 1'b1; if_d.in0_a = 8'd4; if_d.in0_b = 8'd4; if_d.mul_ready = 1'b1;
        wait_sig(0, "rw_ready");
        step(); if_d.in0_valid = 1'b0;
        wait_sig(1, "rw_mulv");
        step();
        @(negedge clk); chk("rw_in_wait", flags_d(), F_RESR);
        step(); rst = 1'b1;
        step(); rst = 1'b0; if_d.mul_res_valid = 1'b1; if_d.mul_res = 16'd16;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rw_abandoned", flags_d(), F_NONE);
            step();
        end
        if_d.in0_valid = 1'b1; if_d.in1_valid = 1'b1;
        @(negedge clk);
        chk("rw_first_grant", {if_d.in0_ready, if_d.in1_ready}, 2'b10);

        // Timeout on the TIMEOUT=8 instance.
        do_reset();
        if_d.mul_ready = 1'b1; if_d.out0_ready = 1'b1; if_d.out1_ready = 1'b1;
        if_d.in0_valid = 1'b1; if_d.in0_a = 8'd5; if_d.in0_b = 8'd5;
        @(negedge clk); chk("to_accept", flags_t(), F_IN0);
        step(); if_d.in0_valid = 1'b0;
        @(negedge clk); chk("to_issue", flags_t(), F_MULV);
        step();
        for (int i = 0; i < TO_T; i++) begin
            @(negedge clk);
            chk("to_wait", flags_t(), F_RESR);
            step();
        end
        @(negedge clk); chk("to_pulse", flags_t(), F_ERR);
        step();
        @(negedge clk); chk("to_pulse_once", flags_t(), F_NONE);
        step();
        if_d.in0_valid = 1'b1; if_d.in1_valid = 1'b1;
        @(negedge clk); chk("to_next_grant", flags_t(), F_IN1);

        // Result on the final WAIT cycle of the TIMEOUT=8 instance.
        do_reset();
        if_d.mul_ready = 1'b1; if_d.out0_ready = 1'b1; if_d.out1_ready = 1'b1;
        if_d.in0_valid = 1'b1; if_d.in0_a = 8'd6; if_d.in0_b = 8'd7;
        @(negedge clk); chk("tie_accept", flags_t(), F_IN0);
        step(); if_d.in0_valid = 1'b0;
        @(negedge clk); chk("tie_issue", flags_t(), F_MULV);
        step();
        for (int i = 0; i < TO_T - 1; i++) begin
            @(negedge clk);
            chk("tie_wait", flags_t(), F_RESR);
            step();
        end
        if_d.mul_res_valid = 1'b1; if_d.mul_res = 16'd42;
        @(negedge clk); chk("tie_last_wait", flags_t(), F_RESR);
        step(); if_d.mul_res_valid = 1'b0;
        @(negedge clk); chk("tie_deliver", flags_t(), F_OUT0);
        chk("tie_data", if_t.out_data, 42);
        step();
        @(negedge clk); chk("tie_no_err", flags_t(), F_NONE);

        // Random traffic on the default instance.
        do_reset();
        random_test(4000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
